// File: rtl/key_scan_if.sv
// ============================================================================
// key_scan_if : keypad row/column lines plus the key_vaild/key_code output.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface key_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_vaild;
  logic [3:0] key_code;

  modport master (
    input  row_in,
    output col_out,
    output key_vaild,
    output key_code
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_vaild,
    input  key_code
  );
endinterface

`default_nettype wire

// File: rtl/key_scan.sv
// ============================================================================
// key_scan : 4x4 keypad column scanner with frame-based press/release debounce.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  key_scan_if.master kp
);

  localparam int                 c_DIV_W    = $clog2(SCAN_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]         c_DEB      = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_DEB   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_DEB = 2'd3
  } state_t;

  logic [3:0]         r_row_m;
  logic [3:0]         r_row_s;
  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_col;
  logic [1:0]         r_acc_lows;
  logic [3:0]         r_acc_code;
  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [3:0]         r_cand;
  logic               r_vaild;
  logic [3:0]         r_code;

  logic               w_win_end;
  logic               w_frame_end;
  logic [1:0]         w_samp_lows;
  logic [1:0]         w_samp_row;
  logic [2:0]         w_sum;
  logic [1:0]         w_frame_lows;
  logic [3:0]         w_frame_code;
  logic               w_none;
  logic               w_single;
  logic [3:0]         w_cnt_inc;
  state_t             w_state_nx;
  logic [3:0]         w_cnt_nx;
  logic [3:0]         w_cand_nx;
  logic               w_accept;
  logic [3:0]         w_accept_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_m <= 4'hF;
      r_row_s <= 4'hF;
    end else begin
      r_row_m <= kp.row_in;
      r_row_s <= r_row_m;
    end
  end

  assign w_win_end   = (r_div == c_DIV_LAST);
  assign w_frame_end = w_win_end && (r_col == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_col <= 2'd0;
    end else if (w_win_end) begin
      r_div <= '0;
      r_col <= r_col + 2'd1;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  assign kp.col_out = ~(4'b0001 << r_col);

  // Low-bit count saturates at 2: only NONE / SINGLE / MULTI matter.
  always_comb begin
    w_samp_lows = 2'd0;
    w_samp_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!r_row_s[r]) begin
        if (w_samp_lows != 2'd2) w_samp_lows = w_samp_lows + 2'd1;
        w_samp_row = 2'(r);
      end
    end
  end

  assign w_sum        = {1'b0, r_acc_lows} + {1'b0, w_samp_lows};
  assign w_frame_lows = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_frame_code = (w_samp_lows == 2'd1 && r_acc_lows == 2'd0)
                        ? {w_samp_row, r_col} : r_acc_code;
  assign w_none       = (w_frame_lows == 2'd0);
  assign w_single     = (w_frame_lows == 2'd1);
  assign w_cnt_inc    = r_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_lows <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_frame_end) begin
      r_acc_lows <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_win_end) begin
      r_acc_lows <= w_frame_lows;
      r_acc_code <= w_frame_code;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_cand_nx     = r_cand;
    w_accept      = 1'b0;
    w_accept_code = r_cand;
    if (w_frame_end) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nx = w_frame_code;
            if (DEBOUNCE_CNT == 1) begin
              w_accept      = 1'b1;
              w_accept_code = w_frame_code;
              w_state_nx    = S_HELD;
              w_cnt_nx      = 4'd0;
            end else begin
              w_state_nx = S_PRESS_DEB;
              w_cnt_nx   = 4'd1;
            end
          end
        end
        S_PRESS_DEB: begin
          if (w_single && w_frame_code == r_cand) begin
            if (w_cnt_inc == c_DEB) begin
              w_accept   = 1'b1;
              w_state_nx = S_HELD;
              w_cnt_nx   = 4'd0;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else if (w_single) begin
            w_cand_nx = w_frame_code;
            w_cnt_nx  = 4'd1;
          end else begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = 4'd0;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (DEBOUNCE_CNT == 1) begin
              w_state_nx = S_IDLE;
              w_cnt_nx   = 4'd0;
            end else begin
              w_state_nx = S_RELEASE_DEB;
              w_cnt_nx   = 4'd1;
            end
          end
        end
        S_RELEASE_DEB: begin
          if (w_none) begin
            if (w_cnt_inc == c_DEB) begin
              w_state_nx = S_IDLE;
              w_cnt_nx   = 4'd0;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_state_nx = S_HELD;
            w_cnt_nx   = 4'd0;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cand  <= 4'd0;
      r_vaild <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
      r_vaild <= w_accept;
      if (w_accept) r_code <= w_accept_code;
    end
  end

  assign kp.key_vaild = r_vaild;
  assign kp.key_code  = r_code;

endmodule

`default_nettype wire
